cu_vertex_cache_request_arbiter: RTL and testbench

- Shares one vertex-cache read-command port among NUM_REQUESTERS compute-unit requesters using round-robin arbitration.
- Each requester gets per-requester outstanding-read credits.
- Cache responses are routed back to the issuing requester by tag.
- Sits between the per-CU read-command generators and the vertex cache reuse/base module; sequences its enable/drain on job boundaries.

---
 rtl/cu_vertex_cache_request_arbiter_pkg.sv | 29 ++
 rtl/cu_vertex_cache_request_arbiter_if.sv | 37 +++
 rtl/cu_vertex_cache_request_arbiter_rr_priority_select.sv | 38 +++
 rtl/cu_vertex_cache_request_arbiter.sv | 157 +++++++++++++++
 tb/tb_cu_vertex_cache_request_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_vertex_cache_request_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cu_vertex_cache_request_arbiter_pkg
// Shared types and constants for the compute-unit vertex-cache request
// arbiter.
//   arb_state_t        : arbiter sequencing states (DISABLED / RUN / DRAIN)
//   ST_*               : legacy-compatible logic encodings of those states
//   DEFAULT_MAX_OUTSTANDING : default per-requester in-flight read cap
//   credit_width()     : bits needed to count 0..max_outstanding inclusive
// ---------------------------------------------------------------------------
package cu_vertex_cache_request_arbiter_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2
  } arb_state_t;

  localparam logic [1:0] ST_DISABLED = DISABLED;
  localparam logic [1:0] ST_RUN      = RUN;
  localparam logic [1:0] ST_DRAIN    = DRAIN;

  localparam int DEFAULT_MAX_OUTSTANDING = 8;

  // One extra bit so the counter can hold the cap value itself.
  function automatic int credit_width(input int max_outstanding);
    return $clog2(max_outstanding) + 1;
  endfunction

endpackage

// File: rtl/cu_vertex_cache_request_arbiter_if.sv
// ---------------------------------------------------------------------------
// cu_vertex_cache_request_arbiter_if
// Bundles the requester-side, cache-command and cache-response signals of
// the vertex-cache request arbiter.
//   req_valid_in / req_cmd_in / req_ready_out : per-requester command handshake
//   cmd_valid_out / cmd_out / cmd_tag_out / cmd_ready_in : cache command port
//   rsp_valid_in / rsp_tag_in / rsp_valid_out : cache response and routed strobe
// Modports: slave = arbiter side, master = requester/cache side.
// ---------------------------------------------------------------------------
interface cu_vertex_cache_request_arbiter_if #(
  parameter int NUM_REQUESTERS = 2,
  parameter int CMD_W          = 64,
  parameter int ID_W           = 3
);

  logic [NUM_REQUESTERS-1:0]       req_valid_in;
  logic [NUM_REQUESTERS*CMD_W-1:0] req_cmd_in;
  logic [NUM_REQUESTERS-1:0]       req_ready_out;
  logic                            cmd_valid_out;
  logic [CMD_W-1:0]                cmd_out;
  logic [ID_W-1:0]                 cmd_tag_out;
  logic                            cmd_ready_in;
  logic                            rsp_valid_in;
  logic [ID_W-1:0]                 rsp_tag_in;
  logic [NUM_REQUESTERS-1:0]       rsp_valid_out;

  modport slave (
    input  req_valid_in, req_cmd_in, cmd_ready_in, rsp_valid_in, rsp_tag_in,
    output req_ready_out, cmd_valid_out, cmd_out, cmd_tag_out, rsp_valid_out
  );

  modport master (
    output req_valid_in, req_cmd_in, cmd_ready_in, rsp_valid_in, rsp_tag_in,
    input  req_ready_out, cmd_valid_out, cmd_out, cmd_tag_out, rsp_valid_out
  );

endinterface

// File: rtl/cu_vertex_cache_request_arbiter_rr_priority_select.sv
// ---------------------------------------------------------------------------
// cu_vertex_cache_request_arbiter_rr_priority_select
// Purely combinational round-robin picker: returns the first asserted
// request at or after the pointer, wrapping from N-1 back to 0.
//   req_i   : request vector
//   ptr_i   : index with highest priority this cycle
//   grant_o : one-hot winner (all zero when nothing requests)
//   idx_o   : binary index of the winner
//   any_o   : a winner exists
// ---------------------------------------------------------------------------
module cu_vertex_cache_request_arbiter_rr_priority_select
  import cu_vertex_cache_request_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan offsets from the pointer; the first hit wins and masks the rest.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (!any_o && req_i[(int'(ptr_i) + off) % N]) begin
        any_o                              = 1'b1;
        grant_o[(int'(ptr_i) + off) % N]   = 1'b1;
        idx_o                              = IDX_W'((int'(ptr_i) + off) % N);
      end
    end
  end

endmodule

// File: rtl/cu_vertex_cache_request_arbiter.sv
// ---------------------------------------------------------------------------
// cu_vertex_cache_request_arbiter
// Shares one vertex-cache read-command port among NUM_REQUESTERS compute-unit
// requesters with round-robin arbitration, per-requester outstanding-read
// credits and tag-based response routing. Enable/drain follows job
// boundaries through a DISABLED / RUN / DRAIN sequencer.
//   clock, rst_in          : clock and synchronous active-high reset
//   enabled_in             : arbitration enable; deassert to drain
//   bus (slave)            : requester, cache command and response signals
//   outstanding_total_out  : registered sum of in-flight reads
//   idle_out               : DISABLED with nothing in flight
//   error_out              : sticky bad-response flag
// ---------------------------------------------------------------------------
module cu_vertex_cache_request_arbiter
  import cu_vertex_cache_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS  = 2,
  parameter int CMD_W           = 64,
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int ID_W            = 3
) (
  input  logic                              clock,
  input  logic                              rst_in,
  input  logic                              enabled_in,
  cu_vertex_cache_request_arbiter_if.slave  bus,
  output logic [7:0]                        outstanding_total_out,
  output logic                              idle_out,
  output logic                              error_out
);

  localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int CNT_W = credit_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQUESTERS - 1);

  logic [1:0]                state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [CNT_W-1:0]          cnt_q [NUM_REQUESTERS];
  logic [CNT_W-1:0]          cnt_d [NUM_REQUESTERS];
  logic                      cmd_valid_q, cmd_valid_d;
  logic [CMD_W-1:0]          cmd_q, cmd_d;
  logic [ID_W-1:0]           tag_q, tag_d;
  logic [NUM_REQUESTERS-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]                total_q, total_d;
  logic                      error_q, error_d;

  logic [NUM_REQUESTERS-1:0] eligible;
  logic [NUM_REQUESTERS-1:0] sel_grant;
  logic [NUM_REQUESTERS-1:0] rsp_hit;
  logic [IDX_W-1:0]          sel_idx;
  logic                      sel_any;
  logic                      grant_en;

  // A requester may win only in RUN, with credit left, and when the output
  // slot is empty or being emptied by the cache this very cycle.
  // A response is honoured only for an in-range tag whose counter is non-zero.
  always_comb begin
    eligible = '0;
    rsp_hit  = '0;
    grant_en = (state_q == ST_RUN) && (!cmd_valid_q || bus.cmd_ready_in);
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      eligible[i] = grant_en && bus.req_valid_in[i] && (cnt_q[i] < CNT_MAX);
      rsp_hit[i]  = bus.rsp_valid_in && (bus.rsp_tag_in == ID_W'(i)) &&
                    (cnt_q[i] != '0);
    end
  end

  cu_vertex_cache_request_arbiter_rr_priority_select #(
    .N     (NUM_REQUESTERS),
    .IDX_W (IDX_W)
  ) u_select (
    .req_i   (eligible),
    .ptr_i   (ptr_q),
    .grant_o (sel_grant),
    .idx_o   (sel_idx),
    .any_o   (sel_any)
  );

  // Sequencer: drain completes only once nothing is held or in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISABLED: if (enabled_in) state_d = ST_RUN;
      ST_RUN:      if (!enabled_in) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (enabled_in)                         state_d = ST_RUN;
        else if (total_q == '0 && !cmd_valid_q) state_d = ST_DISABLED;
      end
      default:     state_d = ST_DISABLED;
    endcase
  end

  // Output slot: a grant loads it (possibly while the old entry leaves),
  // otherwise it empties on handshake and holds its payload while stalled.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_d       = cmd_q;
    tag_d       = tag_q;
    ptr_d       = ptr_q;
    if (sel_any) begin
      cmd_valid_d = 1'b1;
      cmd_d       = bus.req_cmd_in[sel_idx*CMD_W +: CMD_W];
      tag_d       = ID_W'(sel_idx);
      ptr_d       = (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
    end else if (cmd_valid_q && bus.cmd_ready_in) begin
      cmd_valid_d = 1'b0;
    end
  end

  // Credits: accept and response on the same requester cancel out. The total
  // is summed from next-state counters so it lands with them.
  always_comb begin
    total_d     = '0;
    rsp_valid_d = rsp_hit;
    error_d     = error_q || (bus.rsp_valid_in && (rsp_hit == '0));
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sel_grant[i] && !rsp_hit[i])      cnt_d[i] = cnt_q[i] + 1'b1;
      else if (!sel_grant[i] && rsp_hit[i]) cnt_d[i] = cnt_q[i] - 1'b1;
      total_d = total_d + 8'(cnt_d[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (rst_in) begin
      state_q     <= ST_DISABLED;
      ptr_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      tag_q       <= '0;
      rsp_valid_q <= '0;
      total_q     <= '0;
      error_q     <= 1'b0;
      for (int i = 0; i < NUM_REQUESTERS; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      total_q     <= total_d;
      error_q     <= error_d;
      for (int i = 0; i < NUM_REQUESTERS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.req_ready_out     = sel_grant;
  assign bus.cmd_valid_out     = cmd_valid_q;
  assign bus.cmd_out           = cmd_q;
  assign bus.cmd_tag_out       = tag_q;
  assign bus.rsp_valid_out     = rsp_valid_q;
  assign outstanding_total_out = total_q;
  assign idle_out              = (state_q == ST_DISABLED) && (total_q == '0);
  assign error_out             = error_q;

endmodule

// File: tb/tb_cu_vertex_cache_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cu_vertex_cache_request_arbiter
// Directed bench for the vertex-cache request arbiter. Expected issued
// commands are queued as stimulus is driven and popped when the cache
// handshake completes; other outputs are compared at fixed points.
// ---------------------------------------------------------------------------
module tb_cu_vertex_cache_request_arbiter;

  localparam int NREQ = 2;
  localparam int CW   = 64;
  localparam int IW   = 3;

  logic clock;
  logic rst_in;
  logic enabled_in;
  logic [7:0] outstanding_total_out;
  logic idle_out;
  logic error_out;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [IW+CW-1:0] sb_q [$];
  logic [IW+CW-1:0] sb_head;

  cu_vertex_cache_request_arbiter_if #(
    .NUM_REQUESTERS (NREQ),
    .CMD_W          (CW),
    .ID_W           (IW)
  ) bus ();

  cu_vertex_cache_request_arbiter #(
    .NUM_REQUESTERS  (NREQ),
    .CMD_W           (CW),
    .MAX_OUTSTANDING (8),
    .ID_W            (IW)
  ) dut (
    .clock                 (clock),
    .rst_in                (rst_in),
    .enabled_in            (enabled_in),
    .bus                   (bus),
    .outstanding_total_out (outstanding_total_out),
    .idle_out              (idle_out),
    .error_out             (error_out)
  );

  // Free-running clock, posedge every 10 time units.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    total_cnt++;
    assert (observed === expected) else begin
      bad_cnt++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] valid, input logic ready);
    enabled_in        = en;
    bus.req_valid_in  = valid;
    bus.cmd_ready_in  = ready;
  endtask

  task automatic respond(input logic [2:0] tag);
    bus.rsp_valid_in = 1'b1;
    bus.rsp_tag_in   = tag;
    tick();
    bus.rsp_valid_in = 1'b0;
  endtask

  task automatic pushExpected(input logic [2:0] tag, input logic [63:0] cmd);
    sb_q.push_back({tag, cmd});
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput($sformatf("%s_cmd_valid", pfx), 64'(bus.cmd_valid_out), 64'd0);
    checkOutput($sformatf("%s_cmd_out", pfx),   64'(bus.cmd_out),       64'd0);
    checkOutput($sformatf("%s_cmd_tag", pfx),   64'(bus.cmd_tag_out),   64'd0);
    checkOutput($sformatf("%s_rsp_valid", pfx), 64'(bus.rsp_valid_out), 64'd0);
    checkOutput($sformatf("%s_req_ready", pfx), 64'(bus.req_ready_out), 64'd0);
    checkOutput($sformatf("%s_total", pfx),     64'(outstanding_total_out), 64'd0);
    checkOutput($sformatf("%s_idle", pfx),      64'(idle_out),          64'd1);
    checkOutput($sformatf("%s_error", pfx),     64'(error_out),         64'd0);
  endtask

  // Scoreboard: every completed cache handshake must match the oldest
  // expected command.
  always @(negedge clock) begin
    if (!rst_in && bus.cmd_valid_out && bus.cmd_ready_in) begin
      checkOutput("sb_pending", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        sb_head = sb_q.pop_front();
        checkOutput("issue_tag", 64'(bus.cmd_tag_out), 64'(sb_head[IW+CW-1:CW]));
        checkOutput("issue_cmd", bus.cmd_out, sb_head[CW-1:0]);
      end
    end
  end

  initial begin
    rst_in           = 1'b1;
    enabled_in       = 1'b0;
    bus.req_valid_in = '0;
    bus.req_cmd_in   = '0;
    bus.cmd_ready_in = 1'b0;
    bus.rsp_valid_in = 1'b0;
    bus.rsp_tag_in   = '0;
    tick();
    tick();
    checkResetValues("por");
    rst_in = 1'b0;

    // Both requesters always valid: strict alternation starting at 0.
    bus.req_cmd_in = {64'hB1, 64'hA0};
    for (int k = 0; k < 2; k++) begin
      pushExpected(3'd0, 64'hA0);
      pushExpected(3'd1, 64'hB1);
    end
    applyStimulus(1'b1, 2'b11, 1'b1);
    tick();
    checkOutput("t1_ready_a", 64'(bus.req_ready_out), 64'd1);
    tick();
    checkOutput("t1_ready_b", 64'(bus.req_ready_out), 64'd2);
    tick();
    checkOutput("t1_ready_c", 64'(bus.req_ready_out), 64'd1);
    tick();
    checkOutput("t1_ready_d", 64'(bus.req_ready_out), 64'd2);
    tick();
    applyStimulus(1'b1, 2'b00, 1'b1);
    checkOutput("t1_total", 64'(outstanding_total_out), 64'd4);
    tick();
    for (int k = 0; k < 4; k++) begin
      respond(3'(k % 2));
      checkOutput("t1_rsp_strobe", 64'(bus.rsp_valid_out), 64'(1 << (k % 2)));
    end
    checkOutput("t1_total_zero", 64'(outstanding_total_out), 64'd0);

    // Requester 0 alone runs out of credit after 8, one response frees one.
    bus.req_cmd_in = {64'hB1, 64'hA2};
    for (int k = 0; k < 8; k++) pushExpected(3'd0, 64'hA2);
    applyStimulus(1'b1, 2'b01, 1'b1);
    #1;
    checkOutput("t2_ready_first", 64'(bus.req_ready_out), 64'd1);
    repeat (8) tick();
    checkOutput("t2_ready_capped", 64'(bus.req_ready_out), 64'd0);
    checkOutput("t2_total_capped", 64'(outstanding_total_out), 64'd8);
    tick();
    checkOutput("t2_still_capped", 64'(bus.req_ready_out), 64'd0);
    checkOutput("t2_slot_empty", 64'(bus.cmd_valid_out), 64'd0);
    pushExpected(3'd0, 64'hA2);
    respond(3'd0);
    checkOutput("t2_rsp_strobe", 64'(bus.rsp_valid_out), 64'd1);
    checkOutput("t2_total_seven", 64'(outstanding_total_out), 64'd7);
    checkOutput("t2_ready_reopen", 64'(bus.req_ready_out), 64'd1);
    tick();
    checkOutput("t2_ninth_valid", 64'(bus.cmd_valid_out), 64'd1);
    checkOutput("t2_recapped", 64'(bus.req_ready_out), 64'd0);
    applyStimulus(1'b1, 2'b00, 1'b1);
    for (int k = 0; k < 8; k++) respond(3'd0);
    checkOutput("t2_total_zero", 64'(outstanding_total_out), 64'd0);

    // Stalled cache: held command is stable and no new grants appear.
    bus.req_cmd_in = {64'hD1, 64'hC0};
    applyStimulus(1'b1, 2'b11, 1'b0);
    pushExpected(3'd1, 64'hD1);
    #1;
    checkOutput("t3_ready_first", 64'(bus.req_ready_out), 64'd2);
    tick();
    bus.req_cmd_in = {64'hE1, 64'hC0};
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("t3_hold_cmd", bus.cmd_out, 64'hD1);
      checkOutput("t3_hold_tag", 64'(bus.cmd_tag_out), 64'd1);
      checkOutput("t3_hold_ready", 64'(bus.req_ready_out), 64'd0);
      tick();
    end
    applyStimulus(1'b1, 2'b11, 1'b1);
    pushExpected(3'd0, 64'hC0);
    #1;
    checkOutput("t3_resume_ready", 64'(bus.req_ready_out), 64'd1);
    tick();
    applyStimulus(1'b1, 2'b00, 1'b1);
    checkOutput("t3_next_cmd", bus.cmd_out, 64'hC0);
    checkOutput("t3_next_tag", 64'(bus.cmd_tag_out), 64'd0);
    tick();

    // Three in flight, then drain with no grants until all are answered.
    applyStimulus(1'b1, 2'b01, 1'b1);
    pushExpected(3'd0, 64'hC0);
    tick();
    applyStimulus(1'b1, 2'b00, 1'b1);
    tick();
    checkOutput("t4_total_three", 64'(outstanding_total_out), 64'd3);
    applyStimulus(1'b0, 2'b00, 1'b1);
    tick();
    checkOutput("t4_drain_not_idle", 64'(idle_out), 64'd0);
    applyStimulus(1'b0, 2'b11, 1'b1);
    #1;
    checkOutput("t4_drain_no_grant", 64'(bus.req_ready_out), 64'd0);
    tick();
    checkOutput("t4_drain_slot", 64'(bus.cmd_valid_out), 64'd0);
    applyStimulus(1'b0, 2'b00, 1'b1);
    respond(3'd0);
    checkOutput("t4_rsp_a", 64'(bus.rsp_valid_out), 64'd1);
    respond(3'd1);
    checkOutput("t4_rsp_b", 64'(bus.rsp_valid_out), 64'd2);
    respond(3'd0);
    checkOutput("t4_rsp_c", 64'(bus.rsp_valid_out), 64'd1);
    checkOutput("t4_total_zero", 64'(outstanding_total_out), 64'd0);
    checkOutput("t4_idle_late", 64'(idle_out), 64'd0);
    tick();
    checkOutput("t4_idle", 64'(idle_out), 64'd1);

    // Requester 1 at four credits: simultaneous accept and response.
    bus.req_cmd_in = {64'hF1, 64'hC0};
    applyStimulus(1'b1, 2'b00, 1'b1);
    tick();
    applyStimulus(1'b1, 2'b10, 1'b1);
    for (int k = 0; k < 4; k++) pushExpected(3'd1, 64'hF1);
    repeat (4) tick();
    checkOutput("t5_total_four", 64'(outstanding_total_out), 64'd4);
    pushExpected(3'd1, 64'hF1);
    bus.rsp_valid_in = 1'b1;
    bus.rsp_tag_in   = 3'd1;
    #1;
    checkOutput("t5_ready_same", 64'(bus.req_ready_out), 64'd2);
    tick();
    bus.rsp_valid_in = 1'b0;
    applyStimulus(1'b1, 2'b00, 1'b1);
    checkOutput("t5_rsp_strobe", 64'(bus.rsp_valid_out), 64'd2);
    checkOutput("t5_total_hold", 64'(outstanding_total_out), 64'd4);
    for (int k = 0; k < 4; k++) respond(3'd1);
    checkOutput("t5_total_zero", 64'(outstanding_total_out), 64'd0);

    // Response to a requester with no credit.
    respond(3'd1);
    checkOutput("t6_no_strobe", 64'(bus.rsp_valid_out), 64'd0);
    checkOutput("t6_error", 64'(error_out), 64'd1);
    tick();
    checkOutput("t6_error_sticky", 64'(error_out), 64'd1);

    // Reset while a command is held and a response is arriving.
    applyStimulus(1'b1, 2'b11, 1'b0);
    repeat (3) tick();
    checkOutput("t7_pending", 64'(bus.cmd_valid_out), 64'd1);
    rst_in           = 1'b1;
    bus.rsp_valid_in = 1'b1;
    bus.rsp_tag_in   = 3'd0;
    tick();
    rst_in           = 1'b0;
    bus.rsp_valid_in = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b1);
    checkResetValues("mid");
    tick();
    checkOutput("t7_no_route", 64'(bus.rsp_valid_out), 64'd0);

    // Out-of-range tag.
    respond(3'd3);
    checkOutput("t8_bad_tag_strobe", 64'(bus.rsp_valid_out), 64'd0);
    checkOutput("t8_bad_tag_error", 64'(error_out), 64'd1);
    tick();

    checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
